// File: rtl/order_queue_ctrl_if.sv
// Handshake/status bundle for the in-order dispatch queue.
// The queue owner (slave) receives requests and drives status back to the issuing side (master).
interface order_queue_ctrl_if #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] inData;
  logic             new_data;
  logic             out_data;
  logic             flush;
  logic             rollback;
  logic [AW:0]      rb_ptr;
  logic [WIDTH-1:0] outData;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [AW:0]      count;
  logic [AW:0]      tail_ptr;
  logic [1:0]       err;

  modport master (
    output inData, new_data, out_data, flush, rollback, rb_ptr,
    input  outData, full, empty, almost_full, count, tail_ptr, err
  );

  modport slave (
    input  inData, new_data, out_data, flush, rollback, rb_ptr,
    output outData, full, empty, almost_full, count, tail_ptr, err
  );
endinterface

// File: rtl/order_queue_ctrl.sv
// In-order dispatch queue: records issued Rd tags and releases them in program order at commit.
// Circular buffer with wrap-bit pointers, tail checkpoint/rollback, flush and sticky error flags.
module order_queue_ctrl #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AF_LEVEL = 28
) (
  input logic              clock,
  input logic              reset_n,
  order_queue_ctrl_if.slave q
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic [1:0]    err_q, err_d;

  logic          push_ok;
  logic          pop_ok;
  logic [PW-1:0] rb_off;
  logic [PW-1:0] live;

  // Next-state: flush beats rollback beats push; pop is only blocked by flush or empty.
  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rb_off  = '0;
    live    = '0;

    pop_ok = q.out_data && !empty_q && !q.flush;
    if (q.out_data && empty_q && !q.flush) err_d[1] = 1'b1;
    rd_d = rd_q + PW'(pop_ok);

    if (q.flush) begin
      wr_d = rd_q;
    end else if (q.rollback) begin
      // A snapshot older than the (post-pop) head points at committed entries: empty instead.
      rb_off = q.rb_ptr - rd_d;
      live   = wr_q - rd_d;
      wr_d   = (rb_off <= live) ? q.rb_ptr : rd_d;
    end else begin
      push_ok = q.new_data && !full_q;
      if (q.new_data && full_q) err_d[0] = 1'b1;
      wr_d = wr_q + PW'(push_ok);
    end

    count_d = wr_d - rd_d;
    empty_d = (count_d == '0);
    full_d  = (count_d == PW'(DEPTH));
    af_d    = (count_d >= PW'(AF_LEVEL));
  end

  // Pointer, flag and error registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      err_q   <= err_d;
    end
  end

  // Tag storage is not reset; the head is masked while empty.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= q.inData;
  end

  assign q.outData     = empty_q ? '0 : mem_q[rd_q[AW-1:0]];
  assign q.full        = full_q;
  assign q.empty       = empty_q;
  assign q.almost_full = af_q;
  assign q.count       = count_q;
  assign q.tail_ptr    = wr_q;
  assign q.err         = err_q;
endmodule

// File: tb/tb_order_queue_ctrl.sv
// Self-checking bench for order_queue_ctrl: a tag scoreboard plus pointer/error model.
module tb_order_queue_ctrl;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AFL   = 28;

  logic clock;
  logic reset_n;

  order_queue_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  order_queue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .q       (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int failures;
  logic [WIDTH-1:0] exp_q [$];
  int m_rd;
  int m_wr;
  logic [1:0] m_err;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = exp_q.size();
    check_val("count", int'(bus.count), n);
    check_val("empty", int'(bus.empty), int'(n == 0));
    check_val("full", int'(bus.full), int'(n == int'(DEPTH)));
    check_val("almost_full", int'(bus.almost_full), int'(n >= int'(AFL)));
    check_val("tail_ptr", int'(bus.tail_ptr), m_wr);
    check_val("err", int'(bus.err), int'(m_err));
    check_val("head", int'(bus.outData), (n == 0) ? 0 : int'(exp_q[0]));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #3;
    exp_q.delete();
    m_rd  = 0;
    m_wr  = 0;
    m_err = 2'b00;
    @(negedge clock);
    reset_n = 1'b1;
    check_state();
  endtask

  // One clock of stimulus: the model is advanced, inputs applied across the edge, state checked.
  task automatic op(input logic p, input logic [WIDTH-1:0] tag, input logic c,
                    input logic f, input logic r, input logic [5:0] rp);
    int n;
    int keep;
    logic [WIDTH-1:0] t;
    @(negedge clock);
    n = exp_q.size();
    if (f) begin
      exp_q.delete();
      m_wr = m_rd;
    end else begin
      if (c && n == 0) m_err[1] = 1'b1;
      if (c && n > 0) begin
        t = exp_q.pop_front();
        check_val("commit_tag", int'(bus.outData), int'(t));
        m_rd = (m_rd + 1) % 64;
      end
      if (r) begin
        keep = (int'(rp) - m_rd + 64) % 64;
        if (keep <= exp_q.size()) begin
          while (exp_q.size() > keep) void'(exp_q.pop_back());
          m_wr = int'(rp);
        end else begin
          exp_q.delete();
          m_wr = m_rd;
        end
      end else if (p) begin
        if (n == int'(DEPTH)) m_err[0] = 1'b1;
        else begin
          exp_q.push_back(tag);
          m_wr = (m_wr + 1) % 64;
        end
      end
    end
    bus.new_data = p;
    bus.inData   = tag;
    bus.out_data = c;
    bus.flush    = f;
    bus.rollback = r;
    bus.rb_ptr   = rp;
    @(posedge clock);
    #1;
    bus.new_data = 1'b0;
    bus.out_data = 1'b0;
    bus.flush    = 1'b0;
    bus.rollback = 1'b0;
    #1;
    check_state();
  endtask

  task automatic push(input int tag);
    op(1'b1, WIDTH'(tag), 1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic pop();
    op(1'b0, '0, 1'b1, 1'b0, 1'b0, 6'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.inData = '0; bus.new_data = 1'b0; bus.out_data = 1'b0;
    bus.flush = 1'b0; bus.rollback = 1'b0; bus.rb_ptr = '0;

    // Fill then drain in order.
    do_reset();
    for (int i = 0; i < 32; i++) push(i);
    for (int i = 0; i < 32; i++) pop();

    // Order across the pointer wrap.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20; i++) push(i);
      for (int i = 0; i < 20; i++) pop();
    end
    check_val("wrap_tail", int'(bus.tail_ptr), 40);

    // Rollback to a checkpoint taken after the first push.
    do_reset();
    push(5);
    check_val("snapshot", int'(bus.tail_ptr), 1);
    push(6); push(7); push(8); push(9);
    op(1'b1, 5'd20, 1'b0, 1'b0, 1'b1, 6'd1);
    check_val("rb_count", int'(bus.count), 1);
    push(12);
    pop(); pop();

    // Flush with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 10; i++) push(i + 3);
    op(1'b1, 5'd30, 1'b1, 1'b1, 1'b0, 6'd0);
    check_val("flush_empty", int'(bus.empty), 1);

    // Illegal requests set sticky errors without corrupting flags.
    do_reset();
    pop();
    check_val("underflow_err", int'(bus.err), 2);
    for (int i = 0; i < 32; i++) push(31 - i);
    op(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 6'd0);
    check_val("full_pushpop_count", int'(bus.count), 31);
    check_val("full_pushpop_err", int'(bus.err), 3);

    // Asynchronous reset between edges.
    do_reset();
    for (int i = 0; i < 7; i++) push(i + 1);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    m_rd = 0; m_wr = 0; m_err = 2'b00;
    check_state();
    @(negedge clock);
    reset_n = 1'b1;
    push(3);

    // Mixed random traffic, including out-of-window rollbacks.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic p, c, f, r;
      logic [5:0] rp;
      p  = ($urandom_range(0, 9) < 6);
      c  = ($urandom_range(0, 9) < 4);
      f  = ($urandom_range(0, 59) == 0);
      r  = ($urandom_range(0, 24) == 0);
      rp = 6'((m_rd + int'($urandom_range(0, exp_q.size() + 1))) % 64);
      op(p, WIDTH'($urandom), c, f, r, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
